stopwatch_ctrl: RTL



---
 rtl/stopwatch_ctrl_if.sv | 37 +++
 rtl/stopwatch_ctrl.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl_if.sv
// rtl/stopwatch_ctrl_if.sv - button, counter and display signals of the stopwatch controller
interface stopwatch_ctrl_if #(
    parameter int CNT_W = 10
);
    logic             btn_ss;
    logic             btn_lr;
    logic [CNT_W-1:0] count_in;
    logic             count_en;
    logic             count_clr;
    logic [CNT_W-1:0] dp_count;
    logic             running;
    logic             lap_active;

    // Environment side: buttons and counter value in, strobes and display out
    modport master (
        output btn_ss,
        output btn_lr,
        output count_in,
        input  count_en,
        input  count_clr,
        input  dp_count,
        input  running,
        input  lap_active
    );

    // Controller side
    modport slave (
        input  btn_ss,
        input  btn_lr,
        input  count_in,
        output count_en,
        output count_clr,
        output dp_count,
        output running,
        output lap_active
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - run/stop/lap/clear controller for the stopwatch counter (option: STOPWATCH_AUTOSTOP_EN)
module stopwatch_ctrl #(
    parameter int TICK_DIV  = 500000,
    parameter int CNT_W     = 10,
    parameter int MAX_COUNT = 999
) (
    input  logic             clk,
    input  logic             hard_reset,
    stopwatch_ctrl_if.slave  bus
);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0]    TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] MAX_VAL   = CNT_W'(MAX_COUNT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_LAP  = 2'd2,
        S_STOP = 2'd3
    } state_t;

    state_t           r_state;
    logic [TW-1:0]    r_tick_cnt;
    logic [CNT_W-1:0] r_lap_reg;
    logic             r_ss_q;
    logic             r_lr_q;
    logic             r_count_en;
    logic             r_count_clr;
    logic [CNT_W-1:0] r_dp_count;
    logic             r_running;
    logic             r_lap_active;

    state_t           w_next_state;
    logic [TW-1:0]    w_next_tick;
    logic             w_ss_p;
    logic             w_lr_p;
    logic             w_active;
    logic             w_tick;
    logic             w_at_max;
    logic             w_lap_load;
    logic             w_en;
    logic             w_clr;

    // Press detection, prescaler and next-state/strobe decisions for the coming edge
    always_comb begin
        w_ss_p       = bus.btn_ss & ~r_ss_q;
        // Start/stop wins when both buttons are pressed in the same cycle
        w_lr_p       = bus.btn_lr & ~r_lr_q & ~w_ss_p;
        w_active     = (r_state == S_RUN) || (r_state == S_LAP);
        w_tick       = w_active && (r_tick_cnt == TICK_LAST);
        w_at_max     = (bus.count_in == MAX_VAL);
        w_next_state = r_state;
        w_next_tick  = r_tick_cnt;
        w_lap_load   = 1'b0;
        w_en         = 1'b0;
        w_clr        = 1'b0;

        if (w_active) begin
            w_next_tick = w_tick ? '0 : r_tick_cnt + 1'b1;
        end

        case (r_state)
            S_IDLE: begin
                if (w_ss_p) begin
                    w_next_state = S_RUN;
                    w_next_tick  = '0;
                end
            end
            S_RUN: begin
                if (w_ss_p) begin
                    w_next_state = S_STOP;
                end else if (w_lr_p) begin
                    w_next_state = S_LAP;
                    w_lap_load   = 1'b1;
                end
            end
            S_LAP: begin
                if (w_ss_p) begin
                    w_next_state = S_STOP;
                end else if (w_lr_p) begin
                    w_next_state = S_RUN;
                end
            end
            S_STOP: begin
`ifdef STOPWATCH_AUTOSTOP_EN
                // A counter parked at its last value can only be cleared, not resumed
                if (w_ss_p && !w_at_max) begin
`else
                if (w_ss_p) begin
`endif
                    // Resume keeps the partial prescaler count
                    w_next_state = S_RUN;
                end else if (w_lr_p) begin
                    w_next_state = S_IDLE;
                    w_clr        = 1'b1;
                    w_next_tick  = '0;
                end
            end
            default: begin
                w_next_state = S_IDLE;
                w_next_tick  = '0;
            end
        endcase

        if (w_tick) begin
            if (w_at_max) begin
`ifdef STOPWATCH_AUTOSTOP_EN
                w_next_state = S_STOP;
                w_next_tick  = '0;
`else
                // Wrap: clear the counter instead of incrementing past the last value
                w_clr = 1'b1;
`endif
            end else begin
                w_en = 1'b1;
            end
        end
    end

    // State, prescaler, button history and all registered outputs
    always_ff @(posedge clk) begin
        if (hard_reset) begin
            r_state      <= S_IDLE;
            r_tick_cnt   <= '0;
            r_lap_reg    <= '0;
            r_ss_q       <= 1'b1;
            r_lr_q       <= 1'b1;
            r_count_en   <= 1'b0;
            r_count_clr  <= 1'b0;
            r_dp_count   <= '0;
            r_running    <= 1'b0;
            r_lap_active <= 1'b0;
        end else begin
            r_ss_q       <= bus.btn_ss;
            r_lr_q       <= bus.btn_lr;
            r_state      <= w_next_state;
            r_tick_cnt   <= w_next_tick;
            if (w_lap_load) begin
                r_lap_reg <= bus.count_in;
            end
            r_count_en   <= w_en;
            r_count_clr  <= w_clr;
            r_dp_count   <= (r_state == S_LAP) ? r_lap_reg : bus.count_in;
            r_running    <= (w_next_state == S_RUN) || (w_next_state == S_LAP);
            r_lap_active <= (w_next_state == S_LAP);
        end
    end

    assign bus.count_en   = r_count_en;
    assign bus.count_clr  = r_count_clr;
    assign bus.dp_count   = r_dp_count;
    assign bus.running    = r_running;
    assign bus.lap_active = r_lap_active;
endmodule
